// File: rtl/adder_pkg.sv
// Shared definitions for the registered ripple-carry adder family.
package adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 4;

  typedef struct packed {
    logic                           cout;
    logic [ADDER_DEFAULT_WIDTH-1:0] sum;
  } adder_result_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the ripple adder chains WIDTH of these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/four_bit_ripple_adder.sv
// Registered ripple-carry adder: {cout, s} = a + b + cin, one cycle of latency.
// Define ADDER_SIGNED_OVF_EN to add a registered two's-complement overflow flag (ovf).
module four_bit_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
`ifdef ADDER_SIGNED_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  // Result registers only load on valid input so idle cycles keep the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum;
        cout <= c[WIDTH];
      end
    end
  end

`ifdef ADDER_SIGNED_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_four_bit_ripple_adder.sv
// Directed and exhaustive self-checking bench for four_bit_ripple_adder.
module tb_four_bit_ripple_adder;
  import adder_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       out_valid;
  logic [3:0] s;
  logic       cout;
`ifdef ADDER_SIGNED_OVF_EN
  logic       ovf;
`endif

  int tests_run;
  int tests_failed;

  four_bit_ripple_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .s         (s),
`ifdef ADDER_SIGNED_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then step to just after the capturing edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] av,
                               input logic [3:0] bv, input logic cv);
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOvf(input string tag, input logic expected);
`ifdef ADDER_SIGNED_OVF_EN
    checkOutput(tag, {15'd0, ovf}, {15'd0, expected});
`else
    if (expected === 1'bx) $display("[TB] %s", tag);
`endif
  endtask

  initial begin
    adder_result_t exp_r;
    logic          exp_ovf;
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset held for two cycles; checks are {out_valid, cout, s}.
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    checkOutput("reset", {10'd0, out_valid, cout, s}, {10'd0, 1'b0, 1'b0, 4'b0000});
    checkOvf("reset_ovf", 1'b0);

    applyStimulus(1'b0, 1'b1, 4'b0010, 4'b1010, 1'b0);
    checkOutput("first_after_reset", {10'd0, out_valid, cout, s}, {10'd0, 1'b1, 1'b0, 4'b1100});

    applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1);
    checkOutput("full_ripple", {10'd0, out_valid, cout, s}, {10'd0, 1'b1, 1'b1, 4'b0000});
    checkOvf("full_ripple_ovf", 1'b0);

    applyStimulus(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
    checkOutput("max_values", {10'd0, out_valid, cout, s}, {10'd0, 1'b1, 1'b1, 4'b1111});
    checkOvf("max_values_ovf", 1'b0);

    applyStimulus(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
    checkOutput("signed_wrap", {10'd0, out_valid, cout, s}, {10'd0, 1'b1, 1'b0, 4'b1000});
    checkOvf("signed_wrap_ovf", 1'b1);

    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    checkOutput("all_zero", {10'd0, out_valid, cout, s}, {10'd0, 1'b1, 1'b0, 4'b0000});

    // Valid gating: idle cycles must not disturb the held result.
    applyStimulus(1'b0, 1'b1, 4'b0011, 4'b0100, 1'b0);
    checkOutput("gate_load", {10'd0, out_valid, cout, s}, {10'd0, 1'b1, 1'b0, 4'b0111});
    applyStimulus(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1);
    checkOutput("gate_hold1", {10'd0, out_valid, cout, s}, {10'd0, 1'b0, 1'b0, 4'b0111});
    applyStimulus(1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0);
    checkOutput("gate_hold2", {10'd0, out_valid, cout, s}, {10'd0, 1'b0, 1'b0, 4'b0111});

    // Back-to-back results, then reset beating a simultaneous valid.
    applyStimulus(1'b0, 1'b1, 4'd1, 4'd1, 1'b0);
    checkOutput("b2b_1", {10'd0, out_valid, cout, s}, {10'd0, 1'b1, 1'b0, 4'b0010});
    applyStimulus(1'b0, 1'b1, 4'd2, 4'd2, 1'b0);
    checkOutput("b2b_2", {10'd0, out_valid, cout, s}, {10'd0, 1'b1, 1'b0, 4'b0100});
    applyStimulus(1'b0, 1'b1, 4'd7, 4'd8, 1'b1);
    checkOutput("b2b_3", {10'd0, out_valid, cout, s}, {10'd0, 1'b1, 1'b1, 4'b0000});
    applyStimulus(1'b1, 1'b1, 4'd9, 4'd9, 1'b1);
    checkOutput("reset_priority", {10'd0, out_valid, cout, s}, {10'd0, 1'b0, 1'b0, 4'b0000});
    checkOvf("reset_priority_ovf", 1'b0);

    // Exhaustive sweep of every a, b, cin combination.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] av;
      logic [3:0] bv;
      logic       cv;
      logic [4:0] total;
      av    = i[3:0];
      bv    = i[7:4];
      cv    = i[8];
      total = {1'b0, av} + {1'b0, bv} + {4'd0, cv};
      exp_r.cout = total[4];
      exp_r.sum  = total[3:0];
      exp_ovf    = (av[3] == bv[3]) && (exp_r.sum[3] != av[3]);
      applyStimulus(1'b0, 1'b1, av, bv, cv);
      checkOutput($sformatf("sweep_%0d", i), {10'd0, out_valid, cout, s},
                  {10'd0, 1'b1, exp_r.cout, exp_r.sum});
      checkOvf($sformatf("sweep_ovf_%0d", i), exp_ovf);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
